// File: rtl/imem_boot_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_boot_loader_pkg
//   Shared definitions for the serial IMEM boot loader.
//   Holds the IMEM geometry and the loader FSM state encoding.
//   The checksum state only exists when LOADER_CHECKSUM_EN is defined.
// ---------------------------------------------------------------------------
package imem_boot_loader_pkg;

  localparam int IMEM_DEPTH  = 128;
  localparam int IMEM_ADDR_W = 7;

  // Loader FSM states. The codes are fixed so that the optional checksum
  // state can sit at the end without renumbering the others.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CNT_LO = 3'd1,
    ST_CNT_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_FINISH = 3'd5,
    ST_ERROR  = 3'd6
`ifdef LOADER_CHECKSUM_EN
    ,
    ST_CSUM   = 3'd7
`endif
  } loader_state_t;

endpackage

// File: rtl/loader_byte_packer.sv
// ---------------------------------------------------------------------------
// loader_byte_packer
//   Assembles four received bytes into one 32-bit little-endian word.
//   The first byte of a group ends up in word[7:0], the fourth in word[31:24].
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous reset, active low
//   clear       restart byte grouping at byte 0 (start of a new load)
//   byte_valid  a byte is being accepted this cycle
//   byte_data   the accepted byte
//   word        assembled word; complete and stable the cycle after word_valid
//   word_valid  high in the cycle the fourth byte of a group is accepted
// ---------------------------------------------------------------------------
module loader_byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  byte_cnt_q;
  logic [31:0] word_q;

  // Bytes shift in from the top, so after four shifts the first byte has
  // travelled down to bits [7:0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q <= 2'd0;
      word_q     <= 32'd0;
    end else if (clear) begin
      byte_cnt_q <= 2'd0;
    end else if (byte_valid) begin
      byte_cnt_q <= byte_cnt_q + 2'd1;
      word_q     <= {byte_data, word_q[31:8]};
    end
  end

  assign word_valid = byte_valid && (byte_cnt_q == 2'd3);
  assign word       = word_q;

endmodule

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
//   Serial program loader and owner of the 128x32 IMEM write port.
//   Stream format (little-endian): 2-byte word count, then count 32-bit words.
//   Words go to IMEM addresses 0..count-1. The CPU is held for the whole
//   load and receives a one-cycle restart pulse when the load completes.
//
//   Build option LOADER_CHECKSUM_EN: the stream carries one trailing byte,
//   the XOR of every preceding byte (count bytes included). A mismatch ends
//   in ERROR; words already written stay in IMEM.
//
// Ports
//   clk, rst_n    clock (rising edge) and asynchronous active-low reset
//   load_req      one-cycle start pulse, honoured only in IDLE or ERROR
//   rx_valid      byte available on rx_data
//   rx_data       received byte
//   rx_ready      loader takes a byte when rx_valid & rx_ready
//   mem_we        IMEM write enable, one cycle per word
//   mem_waddr     IMEM word address
//   mem_wdata     IMEM write data
//   cpu_hold      stall the CPU while loading or in error
//   cpu_restart   one-cycle pulse: CPU restarts at PC=0
//   load_busy     high in every state except IDLE
//   load_done     sticky success flag, cleared by the next accepted load_req
//   load_error    sticky error flag, cleared by the next accepted load_req
// ---------------------------------------------------------------------------
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              cpu_restart,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_error
);

  loader_state_t     state_q, state_d;
  logic [7:0]        count_lo_q;
  logic [15:0]       word_count_q;
  logic [ADDR_W-1:0] addr_q;
  logic              done_q;
  logic              error_q;

  logic              receiving;
  logic              rx_fire;
  logic              start;
  logic              last_word;
  logic [15:0]       count_full;
  logic              pack_valid;
  logic [31:0]       packed_word;
  logic              word_valid;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  // The receive states are derived straight from the state register so the
  // handshake never loops back through the next-state logic.
`ifdef LOADER_CHECKSUM_EN
  assign receiving = (state_q == ST_CNT_LO) || (state_q == ST_CNT_HI) ||
                     (state_q == ST_DATA)   || (state_q == ST_CSUM);
`else
  assign receiving = (state_q == ST_CNT_LO) || (state_q == ST_CNT_HI) ||
                     (state_q == ST_DATA);
`endif

  assign rx_ready   = receiving;
  assign rx_fire    = rx_valid && receiving;
  assign start      = load_req && ((state_q == ST_IDLE) || (state_q == ST_ERROR));
  assign count_full = {rx_data, count_lo_q};
  assign last_word  = ({{(16-ADDR_W){1'b0}}, addr_q} == (word_count_q - 16'd1));
  assign pack_valid = rx_fire && (state_q == ST_DATA);

  loader_byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start),
    .byte_valid (pack_valid),
    .byte_data  (rx_data),
    .word       (packed_word),
    .word_valid (word_valid)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and port outputs. The write port and CPU controls are pure
  // functions of the state so an asynchronous reset drops them at once.
  always_comb begin
    state_d     = state_q;
    mem_we      = 1'b0;
    mem_waddr   = '0;
    mem_wdata   = 32'd0;
    cpu_hold    = 1'b1;
    cpu_restart = 1'b0;
    load_busy   = 1'b1;

    case (state_q)
      ST_IDLE: begin
        cpu_hold  = 1'b0;
        load_busy = 1'b0;
        if (load_req) state_d = ST_CNT_LO;
      end

      ST_CNT_LO: begin
        if (rx_fire) state_d = ST_CNT_HI;
      end

      ST_CNT_HI: begin
        if (rx_fire) begin
          if (count_full == 16'd0)             state_d = ST_FINISH;
          else if (count_full > 16'(DEPTH))    state_d = ST_ERROR;
          else                                 state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (word_valid) state_d = ST_WRITE;
      end

      // Single write cycle; the receive side is paused meanwhile.
      ST_WRITE: begin
        mem_we    = 1'b1;
        mem_waddr = addr_q;
        mem_wdata = packed_word;
        if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = ST_CSUM;
`else
          state_d = ST_FINISH;
`endif
        end else begin
          state_d = ST_DATA;
        end
      end

`ifdef LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (rx_fire) state_d = (rx_data == csum_q) ? ST_FINISH : ST_ERROR;
      end
`endif

      ST_FINISH: begin
        cpu_restart = 1'b1;
        state_d     = ST_IDLE;
      end

      ST_ERROR: begin
        if (load_req) state_d = ST_CNT_LO;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Count capture, word address and sticky status flags. The flags are set
  // on entry to FINISH/ERROR so they are already visible in that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_lo_q   <= 8'd0;
      word_count_q <= 16'd0;
      addr_q       <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      if (start) begin
        addr_q  <= '0;
        done_q  <= 1'b0;
        error_q <= 1'b0;
      end
      if ((state_q == ST_CNT_LO) && rx_fire) count_lo_q <= rx_data;
      if ((state_q == ST_CNT_HI) && rx_fire) begin
        word_count_q <= count_full;
        addr_q       <= '0;
      end
      // Stop at the last word so the address never wraps past DEPTH-1.
      if ((state_q == ST_WRITE) && !last_word) addr_q <= addr_q + 1'b1;
      if (state_d == ST_FINISH) done_q <= 1'b1;
      if ((state_d == ST_ERROR) && (state_q != ST_ERROR)) error_q <= 1'b1;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running XOR of every byte before the checksum byte itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= 8'd0;
    end else if (start) begin
      csum_q <= 8'd0;
    end else if (rx_fire && (state_q != ST_CSUM)) begin
      csum_q <= csum_q ^ rx_data;
    end
  end
`endif

  assign load_done  = done_q;
  assign load_error = error_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_boot_loader
//   Randomised bench for imem_boot_loader. A stream-level model predicts,
//   cycle by cycle, the handshake, write port, hold/restart and status flags
//   from the position of each accepted byte in the stream. Literal checks
//   pin the directed cases. Honours LOADER_CHECKSUM_EN like the design.
// ---------------------------------------------------------------------------
module tb_imem_boot_loader;

  logic        clk;
  logic        rst_n;
  logic        load_req;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        mem_we;
  logic [6:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        cpu_restart;
  logic        load_busy;
  logic        load_done;
  logic        load_error;

  imem_boot_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_req    (load_req),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .mem_we      (mem_we),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .cpu_hold    (cpu_hold),
    .cpu_restart (cpu_restart),
    .load_busy   (load_busy),
    .load_done   (load_done),
    .load_error  (load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]  stream[$];
  logic [31:0] words[128];
  logic [31:0] img[128];
  int          wr_count      = 0;
  int          restart_count = 0;
  int          last_waddr    = -1;

  // Stream-level model state
  bit          m_active, m_wr, m_fin, m_err, m_done;
  int          m_pos, m_lo, m_cnt, m_widx;
  logic [31:0] m_word;
  logic [7:0]  m_x;
  bit          ready_exp, hold_exp, start_ev, accept_ev, n_wr, n_fin;
  logic [7:0]  b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Per-cycle compare against the model, then advance the model using the
  // inputs present in this cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_active = 0; m_wr = 0; m_fin = 0; m_err = 0; m_done = 0;
      m_pos = 0; m_lo = 0; m_cnt = 0; m_widx = 0; m_word = 0; m_x = 0;
    end else begin
      ready_exp = m_active && !m_wr && !m_fin && !m_err;
      hold_exp  = m_active;
      chk("rx_ready",    32'(rx_ready),    32'(ready_exp));
      chk("mem_we",      32'(mem_we),      32'(m_wr));
      chk("cpu_restart", 32'(cpu_restart), 32'(m_fin));
      chk("cpu_hold",    32'(cpu_hold),    32'(hold_exp));
      chk("load_busy",   32'(load_busy),   32'(hold_exp));
      chk("load_done",   32'(load_done),   32'(m_done));
      chk("load_error",  32'(load_error),  32'(m_err));
      if (m_wr) begin
        chk("mem_waddr", 32'(mem_waddr), 32'(m_widx));
        chk("mem_wdata", mem_wdata, m_word);
      end
      if (mem_we) begin
        img[mem_waddr] = mem_wdata;
        wr_count++;
        last_waddr = int'(mem_waddr);
      end
      if (cpu_restart) restart_count++;

      start_ev  = load_req && (!m_active || m_err);
      accept_ev = ready_exp && rx_valid;
      n_wr = 0;
      n_fin = 0;
      if (m_fin) m_active = 0;
      if (m_wr) begin
        m_widx++;
`ifndef LOADER_CHECKSUM_EN
        if (m_widx == m_cnt) begin
          n_fin = 1;
          m_done = 1;
        end
`endif
      end
      if (accept_ev) begin
        b = rx_data;
        if (m_pos == 0) begin
          m_lo = int'(b);
        end else if (m_pos == 1) begin
          m_cnt = int'(b) * 256 + m_lo;
          if (m_cnt == 0) begin
            n_fin = 1;
            m_done = 1;
          end else if (m_cnt > 128) begin
            m_err = 1;
          end
        end else if (m_pos < 2 + 4 * m_cnt) begin
          m_word = {b, m_word[31:8]};
          if ((m_pos - 2) % 4 == 3) n_wr = 1;
        end else begin
          if (b == m_x) begin
            n_fin = 1;
            m_done = 1;
          end else begin
            m_err = 1;
          end
        end
        m_x = m_x ^ b;
        m_pos++;
      end
      if (start_ev) begin
        m_active = 1; m_pos = 0; m_cnt = 0; m_widx = 0;
        m_done = 0; m_err = 0; m_x = 0;
      end
      m_wr  = n_wr;
      m_fin = n_fin;
    end
  end

  task automatic append_csum();
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] x = 8'd0;
    foreach (stream[i]) x = x ^ stream[i];
    stream.push_back(x);
`endif
  endtask

  task automatic build_stream(input int count);
    stream.delete();
    stream.push_back(8'(count));
    stream.push_back(8'(count >> 8));
    for (int w = 0; w < count; w++)
      for (int k = 0; k < 4; k++) stream.push_back(8'(words[w] >> (8 * k)));
    if (count > 0) append_csum();
  endtask

  // Sends the global stream. abort_after >= 0 pulls reset low right after
  // that many bytes have been accepted.
  task automatic applyStimulus(input bit do_req, input int valid_pct,
                               input bit spurious, input int abort_after);
    int taken = 0;
    @(posedge clk); #2;
    if (do_req) begin
      load_req = 1'b1;
      @(posedge clk); #2;
      load_req = 1'b0;
    end
    for (int i = 0; i < stream.size(); i++) begin
      bit accepted = 0;
      int budget = 0;
      while (!accepted) begin
        rx_valid = (int'($urandom_range(99)) < valid_pct);
        rx_data  = rx_valid ? stream[i] : 8'($urandom);
        load_req = spurious && ($urandom_range(19) == 0);
        @(negedge clk);
        accepted = rx_valid && rx_ready;
        @(posedge clk); #2;
        load_req = 1'b0;
        budget++;
        if (!accepted && budget > 500) begin
          rx_valid = 1'b0;
          timeout_fail("byte_accept");
          return;
        end
      end
      taken++;
      if (taken == abort_after) begin
        rx_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checkReset("async_reset");
        return;
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (load_busy && !load_error && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) timeout_fail(name);
    @(negedge clk);
  endtask

  task automatic checkReset(input string name);
    chk({name, ".rx_ready"},    32'(rx_ready),    32'd0);
    chk({name, ".mem_we"},      32'(mem_we),      32'd0);
    chk({name, ".mem_waddr"},   32'(mem_waddr),   32'd0);
    chk({name, ".mem_wdata"},   mem_wdata,        32'd0);
    chk({name, ".cpu_hold"},    32'(cpu_hold),    32'd0);
    chk({name, ".cpu_restart"}, 32'(cpu_restart), 32'd0);
    chk({name, ".load_busy"},   32'(load_busy),   32'd0);
    chk({name, ".load_done"},   32'(load_done),   32'd0);
    chk({name, ".load_error"},  32'(load_error),  32'd0);
  endtask

  task automatic checkOutput(input string name, input bit done, input bit err, input bit hold);
    chk({name, ".done"},     32'(load_done),  32'(done));
    chk({name, ".error"},    32'(load_error), 32'(err));
    chk({name, ".hold"},     32'(cpu_hold),   32'(hold));
    chk({name, ".rx_ready"}, 32'(rx_ready),   32'd0);
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int wr_base, rs_base, cnt;
    rst_n = 1'b0; load_req = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
    foreach (img[i]) img[i] = 32'd0;
    repeat (3) @(posedge clk);
    #2;
    checkReset("reset");
    rst_n = 1'b1;

    // Directed two-word load
    $display("[TB] two-word load");
    wr_base = wr_count; rs_base = restart_count;
    stream = {8'h02, 8'h00, 8'h04, 8'h12, 8'h9F, 8'hE5, 8'h04, 8'h92, 8'h9F, 8'hE5};
    append_csum();
    applyStimulus(1, 100, 0, -1);
    wait_idle("t1_idle");
    checkOutput("t1", 1, 0, 0);
    chk("t1.img0", img[0], 32'hE59F1204);
    chk("t1.img1", img[1], 32'hE59F9204);
    chk("t1.writes", 32'(wr_count - wr_base), 32'd2);
    chk("t1.restarts", 32'(restart_count - rs_base), 32'd1);

    // Zero-length load
    $display("[TB] zero count");
    wr_base = wr_count;
    stream = {8'h00, 8'h00};
    applyStimulus(1, 100, 0, -1);
    wait_idle("t2_idle");
    checkOutput("t2", 1, 0, 0);
    chk("t2.writes", 32'(wr_count - wr_base), 32'd0);

    // Oversized counts: 129 and 256
    $display("[TB] oversized count");
    stream = {8'h81, 8'h00};
    applyStimulus(1, 100, 0, -1);
    wait_idle("t3_idle");
    checkOutput("t3", 0, 1, 1);
    @(posedge clk); #2; load_req = 1'b1;
    @(posedge clk); #2; load_req = 1'b0;
    @(negedge clk);
    chk("t3.err_cleared", 32'(load_error), 32'd0);
    chk("t3.cnt_lo_ready", 32'(rx_ready), 32'd1);
    stream = {8'h00, 8'h01};
    applyStimulus(0, 100, 0, -1);
    wait_idle("t3b_idle");
    checkOutput("t3b", 0, 1, 1);

    // Full-depth load with random stalls and ignored load_req pulses
    $display("[TB] 128-word load");
    wr_base = wr_count;
    foreach (words[i]) words[i] = $urandom;
    build_stream(128);
    applyStimulus(1, 50, 1, -1);
    wait_idle("t4_idle");
    checkOutput("t4", 1, 0, 0);
    chk("t4.writes", 32'(wr_count - wr_base), 32'd128);
    chk("t4.last_addr", 32'(last_waddr), 32'd127);
    for (int i = 0; i < 128; i++) chk("t4.img", img[i], words[i]);

    // Short random loads
    $display("[TB] random loads");
    for (int r = 0; r < 6; r++) begin
      wr_base = wr_count;
      cnt = int'($urandom_range(12, 1));
      for (int i = 0; i < cnt; i++) words[i] = $urandom;
      build_stream(cnt);
      applyStimulus(1, int'($urandom_range(90, 30)), 1, -1);
      wait_idle("rnd_idle");
      checkOutput("rnd", 1, 0, 0);
      chk("rnd.writes", 32'(wr_count - wr_base), 32'(cnt));
      for (int i = 0; i < cnt; i++) chk("rnd.img", img[i], words[i]);
    end

    // Reset during the second word
    $display("[TB] reset mid-load");
    wr_base = wr_count;
    for (int i = 0; i < 3; i++) words[i] = $urandom;
    build_stream(3);
    applyStimulus(1, 100, 0, 9);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("t5.writes", 32'(wr_count - wr_base), 32'd1);
    chk("t5.img0", img[0], words[0]);
    checkOutput("t5", 0, 0, 0);

`ifdef LOADER_CHECKSUM_EN
    $display("[TB] checksum");
    words[0] = 32'hEA000000;
    build_stream(1);
    applyStimulus(1, 100, 0, -1);
    wait_idle("t6_idle");
    checkOutput("t6", 1, 0, 0);
    stream[stream.size() - 1] = 8'hEC;
    img[0] = 32'd0;
    applyStimulus(1, 100, 0, -1);
    wait_idle("t6b_idle");
    checkOutput("t6b", 0, 1, 1);
    chk("t6b.img0", img[0], 32'hEA000000);
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
